// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encoding,
// parity-mode constants and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Expected parity bit for a word whose bits XOR to data_xor.
    function automatic logic parity_bit(input int mode, input logic data_xor);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous bit; reset value is
// configurable so an idle-high line stays idle through reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable data bits, parity, stop bits
// and oversampling ratio; samples each bit at the middle of its period.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT      = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int OVS       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_ticks,
    input  logic            i_rx,
    output logic            o_rx_done,
    output logic [DBIT-1:0] o_data,
    output logic            o_parity_err,
    output logic            o_frame_err,
    output logic            o_busy
);

    localparam logic [4:0] TICK_MID  = 5'(OVS / 2 - 1);
    localparam logic [4:0] TICK_LAST = 5'(OVS - 1);
    localparam logic [3:0] DBIT_LAST = 4'(DBIT - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    rx_state_t       state;
    logic            rx_s;
    logic            armed;
    logic [4:0]      tick_cnt;
    logic [3:0]      bit_cnt;
    logic [DBIT-1:0] shreg;
    logic            perr;
    logic            ferr;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i_rx),
        .q     (rx_s)
    );

    assign o_busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            armed        <= 1'b0;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            o_rx_done    <= 1'b0;
            o_data       <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // Arming needs a high line first, so a held-low break cannot retrigger.
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed    <= 1'b0;
                        tick_cnt <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_ticks) begin
                        if (tick_cnt == TICK_MID) begin
                            if (!rx_s) begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                perr     <= 1'b0;
                                ferr     <= 1'b0;
                                state    <= ST_DATA;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_ticks) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[DBIT-1:1]};
                            if (bit_cnt == DBIT_LAST) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                ST_PAR: begin
                    if (i_ticks) begin
                        if (tick_cnt == TICK_LAST) begin
                            perr     <= (rx_s != parity_bit(PARITY, ^shreg));
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= ST_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (i_ticks) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                ferr <= 1'b1;
                            end
                            if (bit_cnt == STOP_LAST) begin
                                // Final stop sample also feeds the published flag directly.
                                o_data       <= shreg;
                                o_parity_err <= (PARITY != PAR_NONE) && perr;
                                o_frame_err  <= ferr | ~rx_s;
                                o_rx_done    <= 1'b1;
                                bit_cnt      <= '0;
                                state        <= ST_IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: an 8N1 instance and a 7-bit odd-parity
// two-stop instance, checked against a wire-level frame model.
module tb_uart_rx_cfg;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       ticks = 1'b0;
    logic       rx_a, rx_b;
    logic       done_a, perr_a, ferr_a, busy_a;
    logic [7:0] data_a;
    logic       done_b, perr_b, ferr_b, busy_b;
    logic [6:0] data_b;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;
    int wide_a   = 0;
    int wide_b   = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        int         t;
    } rec_t;

    rec_t qa[$];
    rec_t qb[$];

    uart_rx_cfg dut_a (
        .clk          (clk),
        .reset        (reset),
        .i_ticks      (ticks),
        .i_rx         (rx_a),
        .o_rx_done    (done_a),
        .o_data       (data_a),
        .o_parity_err (perr_a),
        .o_frame_err  (ferr_a),
        .o_busy       (busy_a)
    );

    uart_rx_cfg #(.DBIT(7), .PARITY(2), .STOP_BITS(2), .OVS(OVS)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .i_ticks      (ticks),
        .i_rx         (rx_b),
        .o_rx_done    (done_b),
        .o_data       (data_b),
        .o_parity_err (perr_b),
        .o_frame_err  (ferr_b),
        .o_busy       (busy_b)
    );

    always #5 clk = ~clk;

    // Baud strobe on every other clk, changed on the falling edge.
    always @(negedge clk) ticks <= ~ticks;

    always @(posedge clk) if (ticks) tick_cnt <= tick_cnt + 1;

    always @(negedge clk) begin
        if (done_a) qa.push_back('{{1'b0, data_a}, perr_a, ferr_a, tick_cnt});
        if (done_b) qb.push_back('{{2'b00, data_b}, perr_b, ferr_b, tick_cnt});
        if (done_a && prev_a) wide_a++;
        if (done_b && prev_b) wide_b++;
        prev_a <= done_a;
        prev_b <= done_b;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!ticks) @(posedge clk);
        end
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx_b = v;
        else       rx_a = v;
    endtask

    // Drives one frame and derives the expected result from the wire levels.
    task automatic send(input bit which, input logic [8:0] data, input bit flip_par,
                        input bit bad_stop, output rec_t exp, output int t0);
        logic lv[$];
        int   nb, pm, ns, ones;
        nb = which ? 7 : 8;
        pm = which ? 2 : 0;
        ns = which ? 2 : 1;
        lv.push_back(1'b0);
        for (int i = 0; i < nb; i++) lv.push_back(data[i]);
        ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(data[i]);
        if (pm != 0) lv.push_back(logic'(((pm == 1) ? ones % 2 : 1 - ones % 2) != 0) ^ flip_par);
        for (int i = 0; i < ns; i++) lv.push_back(!(bad_stop && i == ns - 1));

        exp.data = '0;
        for (int i = 0; i < nb; i++) exp.data[i] = lv[1 + i];
        ones = 0;
        for (int i = 0; i < nb; i++) ones += int'(lv[1 + i]);
        if (pm != 0) begin
            ones += int'(lv[1 + nb]);
            exp.perr = (pm == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
        end else begin
            exp.perr = 1'b0;
        end
        exp.ferr = 1'b0;
        for (int i = lv.size() - ns; i < lv.size(); i++) if (!lv[i]) exp.ferr = 1'b1;
        exp.t = 0;

        wait_ticks(1);
        #1;
        t0 = tick_cnt;
        foreach (lv[i]) begin
            set_rx(which, lv[i]);
            wait_ticks(OVS);
            #1;
        end
        set_rx(which, 1'b1);
        wait_ticks(4);
        #1;
    endtask

    task automatic check_frame(input bit which, input rec_t exp, input int t0, input bit lat);
        rec_t got;
        int   n;
        n = which ? qb.size() : qa.size();
        check(which ? "b_done_count" : "a_done_count", n, 1);
        if (n > 0) begin
            got = which ? qb.pop_front() : qa.pop_front();
            check(which ? "b_data" : "a_data", got.data, exp.data);
            check(which ? "b_parity_err" : "a_parity_err", got.perr, exp.perr);
            check(which ? "b_frame_err" : "a_frame_err", got.ferr, exp.ferr);
            check(which ? "b_data_hold" : "a_data_hold",
                  which ? {2'b00, data_b} : {1'b0, data_a}, exp.data);
            if (lat) check("a_latency_in_range",
                           (got.t - t0 >= 151) && (got.t - t0 <= 154), 1);
        end
        qa.delete();
        qb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t e;
        int   t0;
        reset = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_a_data", data_a, 0);
        check("rst_a_flags", {done_a, perr_a, ferr_a, busy_a}, 0);
        check("rst_b_data", data_b, 0);
        check("rst_b_flags", {done_b, perr_b, ferr_b, busy_b}, 0);
        reset = 1'b1;
        wait_ticks(4);
        #1;

        send(0, 9'h0A5, 0, 0, e, t0);
        check_frame(0, e, t0, 1);

        // Short low glitch on an idle line.
        wait_ticks(1); #1;
        rx_a = 1'b0;
        wait_ticks(5); #1;
        check("glitch_busy_high", busy_a, 1);
        rx_a = 1'b1;
        wait_ticks(8); #1;
        check("glitch_busy_low", busy_a, 0);
        wait_ticks(20); #1;
        check("glitch_no_done", qa.size(), 0);

        send(1, 9'h035, 0, 0, e, t0);
        check_frame(1, e, t0, 0);
        send(1, 9'h035, 1, 0, e, t0);
        check_frame(1, e, t0, 0);

        send(0, 9'h03C, 0, 1, e, t0);
        check_frame(0, e, t0, 0);
        send(0, 9'h081, 0, 0, e, t0);
        check_frame(0, e, t0, 0);

        // Break: three frame times low, then release.
        wait_ticks(1); #1;
        rx_a = 1'b0;
        wait_ticks(300); #1;
        check("break_idle_while_low", busy_a, 0);
        wait_ticks(180); #1;
        rx_a = 1'b1;
        wait_ticks(20); #1;
        e.data = '0; e.perr = 1'b0; e.ferr = 1'b1;
        check_frame(0, e, 0, 0);
        send(0, 9'h055, 0, 0, e, t0);
        check_frame(0, e, t0, 0);

        // Reset in the middle of 0xFF, after the fourth data bit.
        wait_ticks(1); #1;
        rx_a = 1'b0;
        wait_ticks(OVS); #1;
        rx_a = 1'b1;
        wait_ticks(4 * OVS); #1;
        check("mid_busy_before_reset", busy_a, 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_data", data_a, 0);
        check("mid_rst_flags", {done_a, perr_a, ferr_a, busy_a}, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_ticks(6 * OVS); #1;
        check("mid_rst_no_done", qa.size(), 0);
        send(0, 9'h012, 0, 0, e, t0);
        check_frame(0, e, t0, 0);

        for (int k = 0; k < 6; k++) begin
            send(0, 9'($urandom_range(0, 255)), 0, ($urandom_range(0, 3) == 0), e, t0);
            check_frame(0, e, t0, 1);
            send(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), e, t0);
            check_frame(1, e, t0, 0);
        end

        check("a_done_one_clk", wide_a, 0);
        check("b_done_one_clk", wide_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DBIT, default 8, meaning number of data bits per frame; legal range 5..9.
REQ-002 Parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, meaning number of stop bits; legal values 1 or 2.
REQ-004 Parameter OVS, default 16, meaning i_ticks per bit period; even, range 8..32.
REQ-005 Port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 Port i_ticks, input, 1, meaning one-clk-wide baud strobe at OVS times the bit rate.
REQ-008 Port i_rx, input, 1, meaning asynchronous serial line, idle high.
REQ-009 Port o_rx_done, output, 1, meaning one-clk pulse per completed frame.
REQ-010 Port o_data, output, DBIT, meaning received word, LSB first on the wire, LSB at bit 0.
REQ-011 Port o_parity_err, output, 1, meaning parity mismatch on the last frame; always 0 when PARITY=0.
REQ-012 Port o_frame_err, output, 1, meaning a stop bit sampled low on the last frame.
REQ-013 Port o_busy, output, 1, meaning high in every state except IDLE.

Function
REQ-014 i_rx SHALL pass a 2-flop synchroniser, with both flops reset to 1; all decisions use the synchronised value rx_s.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PAR and STOP; a tick counter (5 bits) and a bit counter (4 bits) SHALL advance only on i_ticks.
REQ-016 IDLE: the FSM SHALL go to START on a clk where rx_s=0 and the armed flag is 1, clearing the tick counter.
REQ-017 The armed flag SHALL be set whenever rx_s=1 in IDLE and cleared on leaving IDLE, so a held-low line never starts a second frame.
REQ-018 START: at tick count OVS/2-1, rx_s=0 SHALL go to DATA with counters cleared; rx_s=1 is a glitch and SHALL return to IDLE with no done pulse.
REQ-019 DATA: at tick count OVS-1, rx_s SHALL shift into the MSB of the shift register (right shift) and the tick counter SHALL clear.
REQ-020 After DBIT bits, DATA SHALL go to PAR if PARITY!=0, otherwise to STOP.
REQ-021 PAR: at tick OVS-1, the sampled bit SHALL be compared with the XOR of the data (even) or its inverse (odd); the mismatch result SHALL be latched.
REQ-022 STOP: each stop bit SHALL be sampled at tick OVS-1; any low sample SHALL set the frame-error latch.
REQ-023 On the final stop sample, the FSM SHALL go to IDLE and, on the same edge, load o_data, o_parity_err and o_frame_err and assert o_rx_done for exactly one clk.
REQ-024 Latency: o_rx_done SHALL rise on the clk edge of the i_ticks that samples the middle of the last stop bit.
REQ-025 Outputs SHALL hold their values until the next o_rx_done; o_data SHALL be loaded even when an error flag is set.
REQ-026 i_ticks pulses in IDLE SHALL have no effect; the FSM SHALL never wait on anything other than i_ticks.
REQ-027 A break (line low for the whole frame) SHALL complete as a frame with o_data=0 and o_frame_err=1, then wait in IDLE unarmed until rx_s=1.

Reset
REQ-028 While reset=0: FSM in IDLE, counters 0, shift register 0, armed 0, o_rx_done 0, o_data 0, both error flags 0, o_busy 0.
REQ-029 Assertion of reset mid-frame SHALL abort the frame immediately with no done pulse; after release, reception resumes only after the line has been seen high.

Structure
REQ-030 Package uart_pkg SHALL hold the state encoding and the parity-mode constants PAR_NONE, PAR_EVEN and PAR_ODD.
REQ-031 The synchroniser SHALL be a sub-module uart_sync2 (1-bit, with reset value as a parameter); the rest is a single FSM/datapath module.

Verification
REQ-032 Defaults (8N1, OVS 16), send 0xA5 -> one done pulse, o_data=0xA5, both error flags 0, and done occurs 9.5 bit periods after the start edge (+-1 tick).
REQ-033 Low glitch of 5 ticks on an idle line -> no done pulse, o_busy returns to 0 within 8 ticks.
REQ-034 DBIT=7, PARITY=2, STOP_BITS=2, send 0x35 with correct parity and then with flipped parity -> first frame o_parity_err=0, second o_parity_err=1, o_data=0x35 in both.
REQ-035 Send 0x3C with the stop bit driven low -> o_frame_err=1 and o_data=0x3C; the next good frame 0x81 clears the flag.
REQ-036 Line held low for 3 frame times then released, then 0x55 sent -> exactly one break frame (0x00, frame error), then 0x55 received cleanly.
REQ-037 reset pulsed low after the 4th data bit of 0xFF -> no done pulse, all outputs 0; the following 0x12 is received correctly.
